// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: decoder control inputs, instruction-memory handshake and decoder-facing output.
interface fetch_unit_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;

  modport slave (
    input  stall, redirect_valid, redirect_target, imem_ack, imem_rdata,
    output imem_req, imem_addr, instr, instr_pc, instr_valid
  );

  modport master (
    output stall, redirect_valid, redirect_target, imem_ack, imem_rdata,
    input  imem_req, imem_addr, instr, instr_pc, instr_valid
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single outstanding memory request, output register plus skid register,
// redirect with in-flight discard.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  fetch_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DISCARD} state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic        req_q, req_next;
  logic [31:0] addr_q, addr_next;
  logic        out_valid, out_valid_next;
  logic [31:0] out_instr, out_instr_next;
  logic [31:0] out_pc, out_pc_next;
  logic        skid_valid, skid_valid_next;
  logic [31:0] skid_instr, skid_instr_next;
  logic [31:0] skid_pc, skid_pc_next;

  logic        ack;
  logic        consume;
  logic        accept;
  logic [31:0] target;

  // An ack only counts while a request is actually outstanding.
  assign ack     = bus.imem_ack && req_q;
  assign consume = out_valid && !bus.stall;
  assign accept  = ack && (state == REQ) && !bus.redirect_valid;
  assign target  = bus.redirect_target & ~32'h0000_0003;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    state_next = REQ;
      REQ: begin
        if (bus.redirect_valid)            state_next = ack ? REQ : DISCARD;
        else if (accept && skid_valid_next) state_next = HOLD;
      end
      HOLD:    if (!skid_valid_next) state_next = REQ;
      DISCARD: if (ack) state_next = REQ;
      default: state_next = IDLE;
    endcase
  end

  // A fresh address is issued whenever a request starts or the previous one was acked;
  // otherwise the outstanding address is held (this covers DISCARD and pending REQ).
  always_comb begin
    req_next  = (state_next == REQ) || (state_next == DISCARD);
    addr_next = addr_q;
    if ((state_next == REQ) && ((state != REQ) || ack)) addr_next = pc_next;
  end

  always_comb begin
    pc_next         = pc;
    out_valid_next  = out_valid;
    out_instr_next  = out_instr;
    out_pc_next     = out_pc;
    skid_valid_next = skid_valid;
    skid_instr_next = skid_instr;
    skid_pc_next    = skid_pc;
    if (bus.redirect_valid) begin
      out_valid_next  = 1'b0;
      skid_valid_next = 1'b0;
      pc_next         = target;
    end else begin
      if (consume) begin
        out_valid_next  = skid_valid;
        skid_valid_next = 1'b0;
        if (skid_valid) begin
          out_instr_next = skid_instr;
          out_pc_next    = skid_pc;
        end
      end
      // Evaluated after the consume shift so program order is kept.
      if (accept) begin
        if (!out_valid_next) begin
          out_valid_next = 1'b1;
          out_instr_next = bus.imem_rdata;
          out_pc_next    = addr_q;
        end else begin
          skid_valid_next = 1'b1;
          skid_instr_next = bus.imem_rdata;
          skid_pc_next    = addr_q;
        end
        pc_next = addr_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= '0;
      out_valid  <= 1'b0;
      out_instr  <= '0;
      out_pc     <= '0;
      skid_valid <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else begin
      pc         <= pc_next;
      req_q      <= req_next;
      addr_q     <= addr_next;
      out_valid  <= out_valid_next;
      out_instr  <= out_instr_next;
      out_pc     <= out_pc_next;
      skid_valid <= skid_valid_next;
      skid_instr <= skid_instr_next;
      skid_pc    <= skid_pc_next;
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.instr       = out_instr;
  assign bus.instr_pc    = out_pc;
  assign bus.instr_valid = out_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed sequences, a redirect vector table and
// randomized traffic checked against a queue-based reference model.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  bit          mon_en = 1'b0;

  int unsigned lat = 0;
  bit          rand_lat = 1'b0;
  bit          spurious = 1'b0;
  bit          late_ack = 1'b0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  entry_t      m_q[$];
  logic        m_req  = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_pc   = '0;
  bit          m_disc = 1'b0;

  typedef struct {
    logic [31:0] target;
    logic [31:0] exp_addr;
    logic [31:0] exp_next;
    bit          stall;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h0C00_0003;
    if (a == 32'h0000_0004) return 32'h0000_0003;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Instruction memory: ack after 'lat' waiting cycles, optional acks with no request.
  initial begin
    int unsigned cnt;
    cnt = 0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.imem_ack) begin
        cnt = 0;
        if (rand_lat) lat = $urandom_range(0, 3);
      end
      bus.imem_ack = 1'b0;
      if (bus.imem_req) begin
        if (cnt >= lat) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = mem_word(bus.imem_addr);
        end else begin
          cnt = cnt + 1;
        end
      end else begin
        cnt = 0;
        if (late_ack || (spurious && $urandom_range(0, 3) == 0)) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = $urandom;
        end
      end
    end
  end

  // Reference model: a two-deep in-order queue, a request flag and a discard flag.
  initial begin
    bit ack;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_q.delete();
        m_req  = 1'b0;
        m_addr = '0;
        m_pc   = 32'h0000_0000;
        m_disc = 1'b0;
      end else begin
        ack = bus.imem_ack && m_req;
        if (bus.redirect_valid) begin
          m_q.delete();
          m_pc = {bus.redirect_target[31:2], 2'b00};
          if (m_req && !ack) begin
            m_disc = 1'b1;
          end else begin
            m_req  = 1'b1;
            m_addr = m_pc;
            m_disc = 1'b0;
          end
        end else begin
          if (m_q.size() > 0 && !bus.stall) void'(m_q.pop_front());
          if (ack) begin
            if (m_disc) begin
              m_disc = 1'b0;
              m_addr = m_pc;
            end else begin
              m_q.push_back('{pc: m_addr, word: bus.imem_rdata});
              m_pc = m_addr + 32'd4;
              if (m_q.size() >= 2) m_req = 1'b0;
              else                 m_addr = m_pc;
            end
          end else if (!m_req && m_q.size() < 2) begin
            m_req  = 1'b1;
            m_addr = m_pc;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("mon_imem_req", 32'(bus.imem_req), 32'(m_req));
        check("mon_imem_addr", bus.imem_addr, m_addr);
        check("mon_instr_valid", 32'(bus.instr_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
          check("mon_instr", bus.instr, m_q[0].word);
          check("mon_instr_pc", bus.instr_pc, m_q[0].pc);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   32'(bus.imem_req), 32'd0);
    check({tag, "_addr"},  bus.imem_addr, 32'd0);
    check({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
    check({tag, "_instr"}, bus.instr, 32'd0);
    check({tag, "_pc"},    bus.instr_pc, 32'd0);
  endtask

  // Returns on the negedge where rst_n is released.
  task automatic do_reset(input bit chk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    if (chk) check_reset_outputs("reset");
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string name, input int unsigned max);
    int unsigned i;
    i = 0;
    while (!bus.instr_valid && i < max) begin
      @(negedge clk);
      i++;
    end
    check(name, 32'(bus.instr_valid), 32'd1);
  endtask

  initial begin
    bus.stall           = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;

    vecs[0] = '{32'h0000_0103, 32'h0000_0100, 32'h0000_0104, 1'b0};
    vecs[1] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0};
    vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1};
    vecs[3] = '{32'h1234_5679, 32'h1234_5678, 32'h1234_567C, 1'b1};
    vecs[4] = '{32'h0000_0002, 32'h0000_0000, 32'h0000_0004, 1'b0};
    vecs[5] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0004, 1'b0};

    // Reset release, back-to-back fetch, then a three-cycle stall.
    lat = 0;
    do_reset(1'b1);
    mon_en = 1'b1;
    @(negedge clk);
    check("first_req", 32'(bus.imem_req), 32'd1);
    check("first_addr", bus.imem_addr, 32'h0);
    @(negedge clk);
    check("first_valid", 32'(bus.instr_valid), 32'd1);
    check("first_pc", bus.instr_pc, 32'h0);
    check("first_instr", bus.instr, 32'h0C00_0003);
    check("second_addr", bus.imem_addr, 32'h4);
    @(negedge clk);
    check("second_pc", bus.instr_pc, 32'h4);
    check("second_instr", bus.instr, 32'h0000_0003);
    bus.stall = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stall_valid", 32'(bus.instr_valid), 32'd1);
      check("stall_pc", bus.instr_pc, 32'h4);
      check("stall_instr", bus.instr, 32'h0000_0003);
      check("stall_req_low", 32'(bus.imem_req), 32'd0);
    end
    bus.stall = 1'b0;
    @(negedge clk);
    check("skid_pc", bus.instr_pc, 32'h8);
    check("skid_instr", bus.instr, mem_word(32'h8));
    check("resume_req", 32'(bus.imem_req), 32'd1);
    check("resume_addr", bus.imem_addr, 32'hC);
    @(negedge clk);
    check("after_skid_pc", bus.instr_pc, 32'hC);

    // Redirect while a slow request is outstanding.
    lat = 3;
    do_reset(1'b0);
    repeat (2) @(negedge clk);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0000_0103;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    check("disc_req", 32'(bus.imem_req), 32'd1);
    check("disc_addr_held", bus.imem_addr, 32'h0);
    check("disc_valid", 32'(bus.instr_valid), 32'd0);
    @(negedge clk);
    check("disc_addr_held2", bus.imem_addr, 32'h0);
    @(negedge clk);
    check("disc_new_addr", bus.imem_addr, 32'h100);
    check("disc_dropped", 32'(bus.instr_valid), 32'd0);
    wait_valid("disc_wait", 20);
    check("disc_pc", bus.instr_pc, 32'h100);
    check("disc_instr", bus.instr, mem_word(32'h100));

    // Redirect coincident with ack under stall.
    lat = 0;
    do_reset(1'b0);
    repeat (2) @(negedge clk);
    bus.stall           = 1'b1;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0000_0200;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    check("coinc_flush", 32'(bus.instr_valid), 32'd0);
    check("coinc_addr", bus.imem_addr, 32'h200);
    check("coinc_req", 32'(bus.imem_req), 32'd1);
    @(negedge clk);
    check("coinc_valid", 32'(bus.instr_valid), 32'd1);
    check("coinc_pc", bus.instr_pc, 32'h200);
    bus.stall = 1'b0;

    // Redirect vector table: target masking and address wrap.
    do_reset(1'b0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      bus.stall           = vecs[i].stall;
      bus.redirect_valid  = 1'b1;
      bus.redirect_target = vecs[i].target;
      @(negedge clk);
      bus.redirect_valid = 1'b0;
      check($sformatf("vec%0d_addr", i), bus.imem_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d_flush", i), 32'(bus.instr_valid), 32'd0);
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), 32'(bus.instr_valid), 32'd1);
      check($sformatf("vec%0d_pc", i), bus.instr_pc, vecs[i].exp_addr);
      check($sformatf("vec%0d_instr", i), bus.instr, mem_word(vecs[i].exp_addr));
      check($sformatf("vec%0d_next", i), bus.imem_addr, vecs[i].exp_next);
      bus.stall = 1'b0;
    end

    // Asynchronous reset mid-request, then a stray ack that must be ignored.
    lat = 3;
    do_reset(1'b0);
    repeat (2) @(negedge clk);
    check("pre_rst_req", 32'(bus.imem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    late_ack = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    late_ack = 1'b0;
    check("restart_req", 32'(bus.imem_req), 32'd1);
    check("restart_addr", bus.imem_addr, 32'h0);
    check("late_ack_ignored", 32'(bus.instr_valid), 32'd0);
    wait_valid("restart_wait", 20);
    check("restart_pc", bus.instr_pc, 32'h0);
    check("restart_instr", bus.instr, 32'h0C00_0003);

    // Randomized traffic against the reference model.
    rand_lat = 1'b1;
    spurious = 1'b1;
    do_reset(1'b0);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      bus.stall           = ($urandom_range(0, 2) == 0);
      bus.redirect_valid  = ($urandom_range(0, 11) == 0);
      bus.redirect_target = $urandom;
    end
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    bus.stall          = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 stall  input  1  decoder not accepting; instr held while high.
REQ-005 redirect_valid  input  1  one-cycle jump/branch redirect strobe.
REQ-006 redirect_target  input  32  new PC; bits [1:0] SHALL be ignored and treated as 00.
REQ-007 imem_req  output  1  registered fetch request to instruction memory.
REQ-008 imem_addr  output  32  registered fetch address; stable while imem_req high.
REQ-009 imem_ack  input  1  one-cycle acknowledge; imem_rdata valid in the same cycle.
REQ-010 imem_rdata  input  32  fetched instruction word.
REQ-011 instr  output  32  instruction word to the decoder's memory input.
REQ-012 instr_pc  output  32  address of instr.
REQ-013 instr_valid  output  1  instr/instr_pc hold a valid instruction.

Function
REQ-014 The FSM SHALL have states IDLE, REQ, HOLD, DISCARD; imem_req SHALL be 1 exactly in REQ and DISCARD.
REQ-015 Consume: an edge with instr_valid=1 and stall=0 SHALL retire the output entry.
REQ-016 Buffering: one output register plus one skid register; program order SHALL be preserved; on consume a valid skid entry SHALL move to the output register.
REQ-017 On an ack edge in REQ: data+imem_addr SHALL go to the output register if it is empty or being consumed and skid is empty, else to skid; pc SHALL become imem_addr+4, wrapping modulo 2^32.
REQ-018 Request handshake: imem_req, once high, SHALL stay high with imem_addr unchanged until an ack edge; ack while imem_req=0 SHALL be ignored.
REQ-019 IDLE -> REQ on the first edge after reset release, imem_addr=pc.
REQ-020 REQ: after an ack edge, SHALL stay REQ with imem_addr=new pc if skid is empty after the edge, else go HOLD; without ack SHALL stay REQ.
REQ-021 HOLD -> REQ with imem_addr=pc on the edge where skid becomes empty.
REQ-022 Latency: instr_valid SHALL rise on the edge that samples imem_ack (1 cycle after ack is presented); zero-wait memory with stall=0 SHALL sustain one instruction per cycle.
REQ-023 Redirect (priority over stall and ack): on a redirect edge output and skid SHALL be flushed (instr_valid=0) and pc=redirect_target.
REQ-024 Redirect in IDLE/HOLD, or in REQ/DISCARD with ack in same cycle: any acked data SHALL be dropped; next state REQ, imem_addr=target.
REQ-025 Redirect in REQ without ack: next state DISCARD, imem_req and old imem_addr held.
REQ-026 DISCARD: on ack, data SHALL be dropped and state -> REQ with imem_addr=pc; a further redirect in DISCARD without ack SHALL update pc and remain DISCARD.
REQ-027 instr and instr_pc SHALL hold their values while instr_valid=1 and stall=1.

Reset
REQ-028 While rst_n=0: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=0, instr=0, instr_pc=0, instr_valid=0, skid empty; asserting rst_n mid-request SHALL abandon the request, and a late ack SHALL be ignored.

Verification
REQ-029 Reset release, zero-wait memory returning 32'h0C00_0003 at 0x0 and 32'h0000_0003 at 0x4, stall=0 -> imem_req rises 1 cycle after release; instr_pc 0x0 then 0x4 on consecutive cycles.
REQ-030 stall=1 for 3 cycles with zero-wait memory -> instr frozen, skid captures one word, imem_req drops (HOLD), no word lost or duplicated after stall=0.
REQ-031 Memory with 3-cycle ack latency, redirect_target=32'h0000_0103 in the cycle after req rises -> state DISCARD, old word dropped, next imem_addr=0x100, next instr_pc=0x100.
REQ-032 Redirect coincident with ack and stall=1 -> acked word dropped, instr_valid=0 next cycle, next imem_addr=target.
REQ-033 pc=32'hFFFF_FFFC acked -> next imem_addr=0x0.
REQ-034 rst_n pulsed low while imem_req=1 -> all outputs at reset values immediately, restart fetch at RESET_PC.
